// File: rtl/nec_pkg.sv
// Shared NEC IR definitions: receiver FSM states, pulse-width windows in microseconds,
// and the snake-game direction codes.
package nec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    REP_STOP
  } nec_state_e;

  localparam int unsigned LEAD_MARK_MIN   = 8000;
  localparam int unsigned LEAD_MARK_MAX   = 10000;
  localparam int unsigned LEAD_SPACE_MIN  = 4000;
  localparam int unsigned LEAD_SPACE_MAX  = 5000;
  localparam int unsigned REP_SPACE_MIN   = 1800;
  localparam int unsigned REP_SPACE_MAX   = 2700;
  localparam int unsigned BIT_MARK_MIN    = 400;
  localparam int unsigned BIT_MARK_MAX    = 750;
  localparam int unsigned BIT0_SPACE_MIN  = 400;
  localparam int unsigned BIT0_SPACE_MAX  = 750;
  localparam int unsigned BIT1_SPACE_MIN  = 1400;
  localparam int unsigned BIT1_SPACE_MAX  = 1900;

  localparam logic [31:0] UP    = 32'h20DF6A95;
  localparam logic [31:0] DOWN  = 32'h20DFEA15;
  localparam logic [31:0] LEFT  = 32'h20DF1AE5;
  localparam logic [31:0] RIGHT = 32'h20DF9A65;

  function automatic logic in_win(input int unsigned w, input int unsigned lo,
                                  input int unsigned hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/nec_us_tick.sv
// Microsecond timebase: divides clk by CLK_FREQ_HZ/1_000_000 into a one-clk tick.
module nec_us_tick #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick_o
);

  localparam int DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= tick_o ? '0 : cnt_q + CW'(1);
  end

endmodule

// File: rtl/nec_ir_receiver.sv
// NEC IR frame decoder producing a held 32-bit code plus valid/repeat/error pulses.
// Define NEC_CHECK_EN to also require address/command complement bytes at the stop mark.
module nec_ir_receiver
  import nec_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int US_CNT_W    = 14
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ir_in,
  output logic [31:0] code,
  output logic        code_valid,
  output logic        repeat_pulse,
  output logic        frame_err
);

  localparam logic [US_CNT_W-1:0] W_SAT = '1;

  logic tick;
  logic sync1_q, sync2_q, prev_q;
  logic fall, rise, any_edge;
  logic [US_CNT_W-1:0] width_q, meas;
  logic [31:0] m;

  nec_state_e  state_q, state_d;
  logic [5:0]  bitcnt_q, bitcnt_d;
  logic [31:0] shift_q, shift_d, code_q, code_d;
  logic        have_q, have_d, wait_q, wait_d;
  logic        valid_q, valid_d, rep_q, rep_d, err_q, err;

  nec_us_tick #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .tick_o (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= ir_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall     = prev_q & ~sync2_q;
  assign rise     = ~prev_q & sync2_q;
  assign any_edge = fall | rise;

  // The measured width includes a tick landing on the edge cycle, so an N us pulse reads N.
  assign meas = (tick && (width_q != W_SAT)) ? width_q + US_CNT_W'(1) : width_q;
  assign m    = 32'(meas);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) width_q <= '0;
    else          width_q <= any_edge ? '0 : meas;
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    have_d   = have_q;
    wait_d   = wait_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    rep_d    = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wait_q) begin
          if (rise) wait_d = 1'b0;
        end else if (fall) begin
          state_d = LEAD_MARK;
        end
      end
      LEAD_MARK: begin
        if (rise) begin
          if (in_win(m, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_d = LEAD_SPACE;
          else                                         err     = 1'b1;
        end else if (m > LEAD_MARK_MAX) err = 1'b1;
      end
      LEAD_SPACE: begin
        if (fall) begin
          if (in_win(m, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
            state_d  = BIT_MARK;
            bitcnt_d = '0;
          end else if (in_win(m, REP_SPACE_MIN, REP_SPACE_MAX)) begin
            state_d = REP_STOP;
          end else err = 1'b1;
        end else if (m > LEAD_SPACE_MAX) err = 1'b1;
      end
      BIT_MARK: begin
        if (rise) begin
          if (in_win(m, BIT_MARK_MIN, BIT_MARK_MAX)) state_d = BIT_SPACE;
          else                                       err     = 1'b1;
        end else if (m > BIT_MARK_MAX) err = 1'b1;
      end
      BIT_SPACE: begin
        if (fall) begin
          if (in_win(m, BIT0_SPACE_MIN, BIT0_SPACE_MAX) ||
              in_win(m, BIT1_SPACE_MIN, BIT1_SPACE_MAX)) begin
            shift_d  = {shift_q[30:0], in_win(m, BIT1_SPACE_MIN, BIT1_SPACE_MAX)};
            bitcnt_d = bitcnt_q + 6'd1;
            state_d  = (bitcnt_q == 6'd31) ? STOP_MARK : BIT_MARK;
          end else err = 1'b1;
        end else if (m > BIT1_SPACE_MAX) err = 1'b1;
      end
      STOP_MARK: begin
        if (rise) begin
          if (in_win(m, BIT_MARK_MIN, BIT_MARK_MAX)) begin
            state_d = IDLE;
`ifdef NEC_CHECK_EN
            if ((shift_q[31:24] == ~shift_q[23:16]) && (shift_q[15:8] == ~shift_q[7:0])) begin
              code_d  = shift_q;
              valid_d = 1'b1;
              have_d  = 1'b1;
            end else err = 1'b1;
`else
            code_d  = shift_q;
            valid_d = 1'b1;
            have_d  = 1'b1;
`endif
          end else err = 1'b1;
        end else if (m > BIT_MARK_MAX) err = 1'b1;
      end
      REP_STOP: begin
        if (rise) begin
          if (in_win(m, BIT_MARK_MIN, BIT_MARK_MAX)) begin
            rep_d   = have_q;
            state_d = IDLE;
          end else err = 1'b1;
        end else if (m > BIT_MARK_MAX) err = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A failure inside a mark leaves the line low; ignore it until the mark ends.
    if (err) begin
      state_d = IDLE;
      wait_d  = ~sync2_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      have_q   <= 1'b0;
      wait_q   <= 1'b0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      rep_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      have_q   <= have_d;
      wait_q   <= wait_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      rep_q    <= rep_d;
      err_q    <= err;
    end
  end

  assign code         = code_q;
  assign code_valid   = valid_q;
  assign repeat_pulse = rep_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_nec_ir_receiver.sv
// Scoreboard bench for nec_ir_receiver: frames are described as mark/space widths in us,
// a window-rule model predicts each outcome, and a monitor checks every output pulse.
module tb_nec_ir_receiver;
  import nec_pkg::*;

  localparam int CLK_HZ = 1_000_000;
  localparam int CPU    = CLK_HZ / 1_000_000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ir_in = 1'b1;
  logic [31:0] code;
  logic        code_valid, repeat_pulse, frame_err;

  nec_ir_receiver #(.CLK_FREQ_HZ(CLK_HZ), .US_CNT_W(14)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ir_in       (ir_in),
    .code        (code),
    .code_valid  (code_valid),
    .repeat_pulse(repeat_pulse),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_CODE = 1, EV_REP = 2, EV_ERR = 3} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [31:0] code;
    int          edgeIdx;
  } exp_t;

  exp_t        expQ[$];
  int          seg[$];
  int          edgeCyc[0:127];
  logic [31:0] mCode = 32'h0;
  bit          mHave = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic int rnd(input int lo, input int hi);
    return int'($urandom_range(32'(hi), 32'(lo)));
  endfunction

  function automatic int wAt(input int w[$], input int p);
    return (p < w.size()) ? w[p] : 1 << 30;
  endfunction

  // Walks the widths through the NEC window rules; the trailing idle gap acts as the next space.
  function automatic void modelFrame(input int gap, output bit has, output exp_t e);
    int w[$];
    int x;
    logic [31:0] val;
    w = seg;
    w.push_back(gap);
    has = 1'b1;
    e.kind = EV_ERR;
    e.code = mCode;
    e.edgeIdx = -1;
    x = wAt(w, 0);
    if (x < 8000 || x > 10000) begin
      e.edgeIdx = (x > 10000) ? -1 : 0;
      return;
    end
    x = wAt(w, 1);
    if (x >= 1800 && x <= 2700) begin
      x = wAt(w, 2);
      if (x < 400 || x > 750) begin
        e.edgeIdx = (x > 750) ? -1 : 2;
        return;
      end
      if (!mHave) begin
        has = 1'b0;
        return;
      end
      e.kind = EV_REP;
      e.edgeIdx = 2;
      return;
    end
    if (x < 4000 || x > 5000) begin
      e.edgeIdx = (x > 5000) ? -1 : 1;
      return;
    end
    val = 32'h0;
    for (int k = 0; k < 32; k++) begin
      x = wAt(w, 2 + 2 * k);
      if (x < 400 || x > 750) begin
        e.edgeIdx = (x > 750) ? -1 : 2 + 2 * k;
        return;
      end
      x = wAt(w, 3 + 2 * k);
      if (x >= 400 && x <= 750)        val = val * 2;
      else if (x >= 1400 && x <= 1900) val = val * 2 + 1;
      else begin
        e.edgeIdx = (x > 1900) ? -1 : 3 + 2 * k;
        return;
      end
    end
    x = wAt(w, 66);
    if (x < 400 || x > 750) begin
      e.edgeIdx = (x > 750) ? -1 : 66;
      return;
    end
    e.edgeIdx = 66;
`ifdef NEC_CHECK_EN
    if ((((val >> 24) ^ (val >> 16)) & 32'hFF) != 32'hFF ||
        (((val >> 8) ^ val) & 32'hFF) != 32'hFF) return;
`endif
    mCode  = val;
    mHave  = 1'b1;
    e.kind = EV_CODE;
    e.code = val;
  endfunction

  // mode 0 nominal, 1 all window minimums, 2 all window maximums, 3 random in-window
  task automatic buildData(input logic [31:0] v, input int mode);
    int lm, ls, bm, s0, s1, sm;
    case (mode)
      0:       begin lm = 9000;  ls = 4500; bm = 560; s0 = 560; s1 = 1690; sm = 560; end
      1:       begin lm = 8000;  ls = 4000; bm = 400; s0 = 400; s1 = 1400; sm = 400; end
      2:       begin lm = 10000; ls = 5000; bm = 750; s0 = 750; s1 = 1900; sm = 750; end
      default: begin
        lm = rnd(8000, 10000); ls = rnd(4000, 5000);
        bm = 560; s0 = 560; s1 = 1690; sm = rnd(400, 750);
      end
    endcase
    seg = {};
    seg.push_back(lm);
    seg.push_back(ls);
    for (int i = 31; i >= 0; i--) begin
      if (mode == 3) begin
        bm = rnd(400, 750); s0 = rnd(400, 750); s1 = rnd(1400, 1900);
      end
      seg.push_back(bm);
      seg.push_back(v[i] ? s1 : s0);
    end
    seg.push_back(sm);
  endtask

  task automatic applyStimulus(input int gap, input bit useModel);
    bit   has;
    exp_t e;
    if (useModel) begin
      modelFrame(gap, has, e);
      if (has) expQ.push_back(e);
    end
    for (int i = 0; i < seg.size(); i++) begin
      ir_in = (i % 2 == 1);
      repeat (seg[i] * CPU) @(posedge clk);
      #1;
      edgeCyc[i] = cyc;
    end
    ir_in = 1'b1;
    repeat (gap * CPU) @(posedge clk);
    #1;
  endtask

  exp_t monE;
  int   monK;

  always @(negedge clk) begin
    if (reset_n && (code_valid || repeat_pulse || frame_err)) begin
      checkOutput("pulse_onehot", 32'(code_valid) + 32'(repeat_pulse) + 32'(frame_err), 32'd1);
      monK = code_valid ? int'(EV_CODE) : (repeat_pulse ? int'(EV_REP) : int'(EV_ERR));
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse actual kind=%0d required=no pulse at cycle %0d", monK, cyc);
      end else begin
        monE = expQ.pop_front();
        checkOutput("pulse_kind", 32'(monK), 32'(int'(monE.kind)));
        checkOutput("code", code, monE.code);
        if (monE.edgeIdx >= 0)
          checkOutput("latency", 32'(cyc - edgeCyc[monE.edgeIdx]), 32'd3);
      end
    end
  end

  initial begin
    #40_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_code", code, 32'h0);
    checkOutput("reset_valid", 32'(code_valid), 32'h0);
    checkOutput("reset_repeat", 32'(repeat_pulse), 32'h0);
    checkOutput("reset_err", 32'(frame_err), 32'h0);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    seg = {9000, 2250, 560};
    applyStimulus(300, 1'b1);

    buildData(UP, 0);
    applyStimulus(300, 1'b1);
    seg = {9000, 2250, 560};
    applyStimulus(300, 1'b1);

    buildData(UP, 1);    applyStimulus(300, 1'b1);
    buildData(DOWN, 2);  applyStimulus(300, 1'b1);
    buildData(LEFT, 0);  applyStimulus(300, 1'b1);
    buildData(RIGHT, 3); applyStimulus(300, 1'b1);
    checkOutput("code_after_dirs", code, mCode);

    seg = {6000};
    applyStimulus(300, 1'b1);
    seg = {7999};
    applyStimulus(300, 1'b1);
    seg = {10001};
    applyStimulus(300, 1'b1);
    seg = {9000, 3999, 560};
    applyStimulus(300, 1'b1);

    buildData(DOWN, 0);
    seg = seg[0:10];
    seg.push_back(1000);
    seg.push_back(560);
    applyStimulus(300, 1'b1);

    buildData(LEFT, 0);
    seg = seg[0:32];
    applyStimulus(5000, 1'b1);

    buildData($urandom(), 3);
    applyStimulus(300, 1'b1);
    checkOutput("code_after_timeout", code, mCode);

    buildData(RIGHT, 0);
    seg = seg[0:20];
    applyStimulus(100, 1'b0);
    reset_n = 1'b0;
    mCode = 32'h0;
    mHave = 1'b0;
    #1;
    checkOutput("midreset_code", code, 32'h0);
    checkOutput("midreset_pulses", {29'h0, code_valid, repeat_pulse, frame_err}, 32'h0);
    repeat (CPU) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;

    buildData(RIGHT, 3);
    applyStimulus(300, 1'b1);
    buildData(32'h20DF6A94, 0);
    applyStimulus(300, 1'b1);
    begin
      logic [7:0] a, c;
      a = 8'($urandom());
      c = 8'($urandom());
      buildData({a, ~a, c, ~c}, 3);
    end
    applyStimulus(300, 1'b1);

    repeat (50) @(posedge clk);
    #1;
    checkOutput("queue_empty", 32'(expQ.size()), 32'h0);
    checkOutput("final_code", code, mCode);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
